core_bht: RTL
=============

CORE_BHT -- requirements
Module: core_bht

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter IDX_W, default 6, giving the number of table index bits (ENTRIES = 2^IDX_W = 64).
REQ-002 The block SHALL have parameter HIST_W, default 4, giving the width of each local branch history register.

Ports (name, direction, width, meaning):
REQ-003 clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 rst, input, 1: asynchronous, active-low reset.
REQ-005 if_pc, input, 10: pc slice of the branch being fetched; bits [IDX_W-1:0] form the read index.
REQ-006 id_pc, input, 10: pc slice of the branch resolving in ID; bits [IDX_W-1:0] form the update index.
REQ-007 update_BP, input, 1: commit a history update for id_pc this cycle.
REQ-008 taken, input, 1: resolved direction for the update (1 = taken).
REQ-009 stall, input, 1: freeze the IF-to-ID pipeline register.
REQ-010 clear_bht, input, 1: request a full table re-initialisation.
REQ-011 BHR_if, output, HIST_W: combinational history for if_pc, feeding PHT index formation in IF.
REQ-012 BHR_id, output, HIST_W: registered copy of BHR_if, aligned with the ID stage for PHT write indexing.
REQ-013 init_busy, output, 1: table clear in progress; predictions are invalid while it is high.

Function
REQ-014 Storage SHALL be ENTRIES x HIST_W registers with no reset; contents SHALL be cleared only by the init FSM.
REQ-015 The FSM SHALL have exactly two states, INIT and RUN; init_busy SHALL be 1 exactly when the state is INIT.
REQ-016 In INIT, one entry per cycle SHALL be written 0 at index init_cnt, and init_cnt SHALL increment by 1.
REQ-017 In INIT with init_cnt = ENTRIES-1, the FSM SHALL write that entry and move to RUN; a full clear SHALL take exactly 64 cycles.
REQ-018 clear_bht = 1 in RUN SHALL move the FSM to INIT with init_cnt = 0 on the next edge.
REQ-019 clear_bht = 1 in INIT SHALL restart the clear, setting init_cnt to 0.
REQ-020 In INIT, BHR_if SHALL read 0 and update_BP SHALL be ignored.
REQ-021 In RUN, update_BP = 1 SHALL write {entry[id_idx][HIST_W-2:0], taken} to entry[id_idx]; the oldest bit shifts out and the newest enters at bit 0.
REQ-022 In RUN, BHR_if SHALL equal entry[if_idx], except as REQ-023 requires.
REQ-023 When update_BP = 1 and if_idx = id_idx in the same cycle, BHR_if SHALL equal the newly shifted value (same-cycle bypass).
REQ-024 When stall = 0, BHR_id SHALL load BHR_if at each edge; when stall = 1, BHR_id SHALL hold its value.
REQ-025 Updates and the bypass SHALL still operate while stall = 1.
REQ-026 Index arithmetic SHALL use unsigned IDX_W bits; init_cnt SHALL be IDX_W+1 bits wide so that termination never relies on wrap-around.

Reset
REQ-027 While rst = 0, the block SHALL immediately set state = INIT, init_cnt = 0, BHR_id = 0 and init_busy = 1.
REQ-028 Reset asserted during any operation SHALL abort it; the full 64-cycle clear SHALL restart after rst deasserts.

Structure
REQ-029 IDX_W/HIST_W defaults and the state encoding (INIT = 1'b0, RUN = 1'b1) SHALL be defined in define.v, shared with core_pht.
REQ-030 The block SHALL be a single flat module with no sub-modules; the bypass mux SHALL live inside core_bht.

Verification
REQ-031 Release rst, hold all inputs at 0 -> init_busy stays high exactly 64 cycles, then drops; BHR_if = 0 for all 64 indices.
REQ-032 After init, update idx 0x16 with taken = 1,1,0,1 on four consecutive cycles -> entry becomes 4'b1101; BHR_if for if_pc = 0x16 reads 1101.
REQ-033 Set entry 0x16 = 1101, then apply update_BP = 1, taken = 0, with if_pc = id_pc = 0x16 -> BHR_if = 1010 in the same cycle; BHR_id = 1010 after the edge.
REQ-034 Apply stall = 1 for 3 cycles while BHR_if changes -> BHR_id holds its prior value; it loads the current BHR_if on the first edge after stall = 0.
REQ-035 Pulse clear_bht at init_cnt = 30 during INIT -> the clear restarts, init_busy lasts 64 more cycles, and an update_BP = 1 during INIT leaves no effect.
REQ-036 Assert rst for one cycle in RUN with non-zero entries -> init_busy = 1 and BHR_id = 0 immediately; all entries read 0 after 64 cycles.

Source files
------------

// File: rtl/core_bht_pkg.sv
// Shared branch-predictor definitions: table geometry defaults and the
// init/run state encoding used by both core_bht and core_pht.
package core_bht_pkg;

    localparam int BHT_IDX_W  = 6;
    localparam int BHT_HIST_W = 4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

endpackage : core_bht_pkg

// File: rtl/core_bht.sv
// Local branch history table: per-PC shift registers read in IF, updated from ID,
// with a same-cycle update bypass and a sequential clear sweep after reset.
module core_bht
    import core_bht_pkg::*;
#(
    parameter int IDX_W  = BHT_IDX_W,
    parameter int HIST_W = BHT_HIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        if_pc,
    input  logic [9:0]        id_pc,
    input  logic              update_BP,
    input  logic              taken,
    input  logic              stall,
    input  logic              clear_bht,
    output logic [HIST_W-1:0] BHR_if,
    output logic [HIST_W-1:0] BHR_id,
    output logic              init_busy
);

    localparam int             ENTRIES  = 1 << IDX_W;
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(ENTRIES - 1);
    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);

    bht_state_e        state_q;
    bht_state_e        state_d;
    logic [IDX_W:0]    init_cnt_q;
    logic [IDX_W:0]    init_cnt_d;

    logic [HIST_W-1:0] mem [ENTRIES];

    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  id_idx;
    logic [HIST_W-1:0] id_hist;
    logic [HIST_W-1:0] shifted;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [HIST_W-1:0] wr_data;

    logic [HIST_W-1:0] bhr_id_q;

    // Upper PC bits do not take part in indexing.
    logic unused_pc;
    assign unused_pc = ^{if_pc[9:IDX_W], id_pc[9:IDX_W]};

    assign if_idx  = if_pc[IDX_W-1:0];
    assign id_idx  = id_pc[IDX_W-1:0];
    assign id_hist = mem[id_idx];
    assign shifted = {id_hist[HIST_W-2:0], taken};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (clear_bht) begin
                    init_cnt_d = '0;
                end else if (init_cnt_q == LAST_IDX) begin
                    state_d    = ST_RUN;
                    init_cnt_d = init_cnt_q + CNT_ONE;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (clear_bht) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase
    end

    // Single write port: the clear sweep owns it in INIT, ID updates in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = id_idx;
        wr_data = shifted;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_cnt_q[IDX_W-1:0];
            wr_data = '0;
        end else if (update_BP) begin
            wr_en   = 1'b1;
        end
    end

    // NOTE: the table has no reset; the INIT sweep zeroes it, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        BHR_if = mem[if_idx];
        if (state_q == ST_INIT) begin
            BHR_if = '0;
        end else if (update_BP && (if_idx == id_idx)) begin
            BHR_if = shifted;
        end
    end

    // Updates keep running under stall; only the IF-to-ID copy freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bhr_id_q <= '0;
        end else if (!stall) begin
            bhr_id_q <= BHR_if;
        end
    end

    assign BHR_id    = bhr_id_q;
    assign init_busy = (state_q == ST_INIT);

endmodule : core_bht
